// File: rtl/approx_mult_seq.sv
// Multi-cycle unsigned WIDTH x WIDTH multiplier reusing one 4x4 nibble multiplier.
// Approximate mode skips partial products whose diagonal i+j falls below DROP.
module approx_mult_seq #(
    parameter int WIDTH = 16,
    parameter int DROP  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] R,
    output logic               busy
);

    localparam int K  = WIDTH / 4;
    localparam int NS = K * K;
    localparam int CW = $clog2(NS);
    localparam int IW = $clog2(K);
    localparam logic [CW-1:0] LAST   = CW'(NS - 1);
    localparam logic [IW-1:0] LAST_I = IW'(K - 1);
    localparam logic [31:0]   DROP_U = 32'(DROP);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      ii;
    logic [IW-1:0]      jj;

    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [7:0]         pp;
    logic [IW:0]        diag;
    logic               skip;
    logic [2*WIDTH-1:0] contrib;
    logic [2*WIDTH-1:0] sum;

    // ii/jj walk the nibble grid alongside cnt so no divider is needed
    always_comb begin
        a_nib   = a_q[{ii, 2'b00} +: 4];
        b_nib   = b_q[{jj, 2'b00} +: 4];
        pp      = {4'b0000, a_nib} * {4'b0000, b_nib};
        diag    = {1'b0, ii} + {1'b0, jj};
        skip    = mode_q && (32'(diag) < DROP_U);
        contrib = '0;
        if (!skip) begin
            contrib = {{(2*WIDTH-8){1'b0}}, pp} << {diag, 2'b00};
        end
        sum = acc + contrib;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            R         <= '0;
            acc       <= '0;
            cnt       <= '0;
            ii        <= '0;
            jj        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            mode_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= A;
                        b_q      <= B;
                        mode_q   <= mode;
                        acc      <= '0;
                        cnt      <= '0;
                        ii       <= '0;
                        jj       <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                    if (ii == LAST_I) begin
                        ii <= '0;
                        jj <= jj + 1'b1;
                    end else begin
                        ii <= ii + 1'b1;
                    end
                    if (cnt == LAST) begin
                        R         <= sum;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
